alarm_controller: RTL and testbench
===================================

// Module: alarm_controller
// PURPOSE
//  Downstream consumer of the alarm-time stage. Compares the BCD alarm time and PM flag with the running clock time.
//  Rings on a new match; handles snooze, stop and ring timeout. Drives the buzzer tone and the status LEDs.
//  All time inputs are packed BCD {H1,H0,M1,M0} (4 bits each), 12-hour format.
// PARAMETERS
//  CLK_HZ          5_000_000  input clock frequency; half-second tick every CLK_HZ/2 cycles (CLK_HZ even)
//  TONE_HZ         2_000      buzzer tone; half period = CLK_HZ/(2*TONE_HZ) cycles
//  RING_SECONDS    60         ring time before auto-stop
//  SNOOZE_SECONDS  300        snooze time before re-ring
//  MAX_SNOOZES     3          snooze limit (used only with ALARM_CTRL_SNOOZE_LIMIT_EN)
// PORTS
//  i_Clk_5MHz       in   1   system clock
//  i_Reset          in   1   asynchronous, active-high reset
//  i_Alarm_Enable   in   1   alarm arm switch (synchronous level)
//  i_Current_Time   in   16  running time, packed BCD
//  i_Current_PM     in   1   running time PM flag
//  i_Alarm_Time     in   16  alarm time, packed BCD
//  i_Alarm_PM       in   1   alarm PM flag
//  i_Snooze         in   1   one-cycle snooze pulse (already debounced)
//  i_Stop           in   1   one-cycle stop pulse (already debounced)
//  o_Alarm_Active   out  1   high in RINGING
//  o_Snoozing       out  1   high in SNOOZE
//  o_Buzzer         out  1   gated tone square wave
// BEHAVIOUR
//  Reset: state DISARMED; all outputs 0; counters 0; r_Match_Prev 0.
//  Match: w_Match = (i_Current_Time==i_Alarm_Time) && (i_Current_PM==i_Alarm_PM).
//   r_Match_Prev <= w_Match every cycle in every state. w_Match_Rise = w_Match & ~r_Match_Prev.
//  FSM:
//   DISARMED -> ARMED when i_Alarm_Enable. No fire on arming while already matched; the rise-edge rule covers this.
//   ARMED -> RINGING on w_Match_Rise. o_Alarm_Active rises the edge after the first equal sample (latency 1 cycle).
//   RINGING -> ARMED on i_Stop, or after RING_SECONDS with no input.
//   RINGING -> SNOOZE on i_Snooze.
//   SNOOZE -> RINGING after SNOOZE_SECONDS, with a fresh ring timer. i_Stop in SNOOZE -> ARMED.
//  Priority every cycle: ~i_Alarm_Enable (any state -> DISARMED, outputs 0 that edge) > i_Stop > i_Snooze > timer expiry.
//  w_Match_Rise in SNOOZE or RINGING is ignored.
//  i_Snooze in ARMED or DISARMED is ignored.
//  Timing: half-second prescaler and half-tick counter clear on every state transition.
//   Durations are exact: RING_SECONDS*CLK_HZ and SNOOZE_SECONDS*CLK_HZ cycles from the entry edge.
//  Buzzer: tone divider runs only in RINGING. It clears on entry, with the tone bit starting 0.
//   Cadence bit is set to 1 on entry and toggles on each half-second tick. o_Buzzer = tone & cadence in RINGING, else 0.
//  Counter widths: $clog2 of the largest count + 1. Counters saturate-free; they clear on expiry or transition.
// CONFIGURATION
//  `ALARM_CTRL_SNOOZE_LIMIT_EN defined:
//   - Snooze counter increments on each RINGING->SNOOZE. It clears on entry to ARMED or DISARMED.
//   - With MAX_SNOOZES snoozes already taken, i_Snooze in RINGING is ignored. Ringing continues until stop or timeout.
//  Undefined: unlimited snoozes. No snooze counter is generated.
// STRUCTURE
//  Package/include alarm_pkg: state encodings (DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3, 2-bit), BCD field offsets.
//  Sub-module alarm_tick_gen: prescaler with sync clear. Outputs a one-cycle half-second tick and the tone toggle enable.
//  Top: match compare, edge register, FSM, half-tick counter, buzzer gating.
// TESTING (bench params: CLK_HZ=20, TONE_HZ=5, RING_SECONDS=3, SNOOZE_SECONDS=2, MAX_SNOOZES=2)
//  1. Enable=1, alarm 16'h0630 PM=0; current steps 16'h0629 -> 16'h0630 PM=0
//     -> o_Alarm_Active=1 one edge later; o_Buzzer period 4 cycles, gated 10 on / 10 off.
//  2. Ring with no input -> o_Alarm_Active falls after exactly 60 cycles. Current time held at 0630 -> no re-ring.
//  3. Ringing, i_Snooze pulse -> o_Snoozing=1, o_Buzzer=0. After 40 cycles -> RINGING again. Then i_Stop -> ARMED.
//  4. i_Snooze and i_Stop in the same cycle while ringing -> ARMED, o_Snoozing stays 0.
//  5. Enable=0 mid-ring -> all outputs 0 next edge. Enable=1 while times equal -> no ring until the next rise.
//  6. Async reset mid-SNOOZE -> outputs 0 immediately. With SNOOZE_LIMIT_EN: third i_Snooze ignored, rings until timeout.
//  7. PM mismatch (alarm 0630 AM, current 0630 PM) -> no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm controller slice:
//   - alarm_state_t : FSM state encoding (DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3)
//   - BCD field offsets of the packed {H1,H0,M1,M0} time word
//   - bcd_time_equal: digit-by-digit comparison of two packed BCD times
// -----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } alarm_state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_M0_LSB  = 0;
    localparam int BCD_M1_LSB  = 4;
    localparam int BCD_H0_LSB  = 8;
    localparam int BCD_H1_LSB  = 12;

    // Compare two packed BCD times one digit at a time.
    function automatic logic bcd_time_equal(input logic [15:0] a, input logic [15:0] b);
        logic eq;
        eq = 1'b1;
        eq = eq & (a[BCD_H1_LSB +: BCD_DIGIT_W] == b[BCD_H1_LSB +: BCD_DIGIT_W]);
        eq = eq & (a[BCD_H0_LSB +: BCD_DIGIT_W] == b[BCD_H0_LSB +: BCD_DIGIT_W]);
        eq = eq & (a[BCD_M1_LSB +: BCD_DIGIT_W] == b[BCD_M1_LSB +: BCD_DIGIT_W]);
        eq = eq & (a[BCD_M0_LSB +: BCD_DIGIT_W] == b[BCD_M0_LSB +: BCD_DIGIT_W]);
        return eq;
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// -----------------------------------------------------------------------------
// alarm_controller_if
// Groups the alarm controller's functional signals.
//   i_Alarm_Enable   arm switch level
//   i_Current_Time   running time, packed BCD {H1,H0,M1,M0}
//   i_Current_PM     running time PM flag
//   i_Alarm_Time     alarm time, packed BCD
//   i_Alarm_PM       alarm PM flag
//   i_Snooze         one-cycle snooze pulse
//   i_Stop           one-cycle stop pulse
//   o_Alarm_Active   high while ringing
//   o_Snoozing       high while snoozing
//   o_Buzzer         gated tone square wave
// Modports: master drives the inputs (time source / buttons / bench),
//           slave is the alarm controller.
// -----------------------------------------------------------------------------
interface alarm_controller_if;
    logic        i_Alarm_Enable;
    logic [15:0] i_Current_Time;
    logic        i_Current_PM;
    logic [15:0] i_Alarm_Time;
    logic        i_Alarm_PM;
    logic        i_Snooze;
    logic        i_Stop;
    logic        o_Alarm_Active;
    logic        o_Snoozing;
    logic        o_Buzzer;

    modport master (
        output i_Alarm_Enable, i_Current_Time, i_Current_PM,
               i_Alarm_Time, i_Alarm_PM, i_Snooze, i_Stop,
        input  o_Alarm_Active, o_Snoozing, o_Buzzer
    );

    modport slave (
        input  i_Alarm_Enable, i_Current_Time, i_Current_PM,
               i_Alarm_Time, i_Alarm_PM, i_Snooze, i_Stop,
        output o_Alarm_Active, o_Snoozing, o_Buzzer
    );
endinterface

// File: rtl/alarm_tick_gen.sv
// -----------------------------------------------------------------------------
// alarm_tick_gen
// Prescalers for the alarm controller.
//   i_Clk          system clock
//   i_Reset        asynchronous active-high reset
//   i_Clear        synchronous clear of both prescalers (state transition)
//   i_Tone_Run     tone divider runs only while high, held at zero otherwise
//   o_Half_Tick    one-cycle pulse every CLK_HZ/2 cycles after a clear
//   o_Tone_Toggle  one-cycle pulse every CLK_HZ/(2*TONE_HZ) cycles while running
// -----------------------------------------------------------------------------
module alarm_tick_gen #(
    parameter int CLK_HZ  = 5_000_000,
    parameter int TONE_HZ = 2_000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Tone_Run,
    output logic o_Half_Tick,
    output logic o_Tone_Toggle
);

    localparam int HALF_CYC = CLK_HZ / 2;
    localparam int TONE_CYC = CLK_HZ / (2 * TONE_HZ);
    localparam int HALF_W   = $clog2(HALF_CYC) + 1;
    localparam int TONE_W   = $clog2(TONE_CYC) + 1;

    logic [HALF_W-1:0] r_Half_Cnt;
    logic [TONE_W-1:0] r_Tone_Cnt;
    logic              w_Half_Last;
    logic              w_Tone_Last;

    assign w_Half_Last   = (r_Half_Cnt == HALF_W'(HALF_CYC - 1));
    assign w_Tone_Last   = (r_Tone_Cnt == TONE_W'(TONE_CYC - 1));
    assign o_Half_Tick   = w_Half_Last;
    assign o_Tone_Toggle = w_Tone_Last & i_Tone_Run;

    // Half-second prescaler: wraps every HALF_CYC cycles, restarts on clear.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Half_Cnt <= '0;
        end else if (i_Clear || w_Half_Last) begin
            r_Half_Cnt <= '0;
        end else begin
            r_Half_Cnt <= r_Half_Cnt + HALF_W'(1);
        end
    end

    // Tone prescaler: idle at zero unless the buzzer is running.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Tone_Cnt <= '0;
        end else if (i_Clear || !i_Tone_Run || w_Tone_Last) begin
            r_Tone_Cnt <= '0;
        end else begin
            r_Tone_Cnt <= r_Tone_Cnt + TONE_W'(1);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
// Compares the running time with the alarm time, rings on a new match and
// handles snooze, stop and the ring / snooze timeouts. Drives the buzzer tone
// (tone gated by a half-second on/off cadence) and the status outputs.
//   i_Clk_5MHz   system clock
//   i_Reset      asynchronous active-high reset
//   io_Bus       alarm_controller_if.slave (inputs, buttons, status, buzzer)
// Optional feature: define ALARM_CTRL_SNOOZE_LIMIT_EN to cap the number of
// snoozes per alarm at MAX_SNOOZES; undefined means unlimited snoozes.
// -----------------------------------------------------------------------------
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int CLK_HZ         = 5_000_000,
    parameter int TONE_HZ        = 2_000,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic              i_Clk_5MHz,
    input  logic              i_Reset,
    alarm_controller_if.slave io_Bus
);

    localparam int RING_HALF   = RING_SECONDS * 2;
    localparam int SNOOZE_HALF = SNOOZE_SECONDS * 2;
    localparam int HALF_MAX    = (RING_HALF > SNOOZE_HALF) ? RING_HALF : SNOOZE_HALF;
    localparam int HT_W        = $clog2(HALF_MAX) + 1;

    // Reject parameter sets the timing scheme cannot represent.
    if ((CLK_HZ % 2) != 0 || TONE_HZ < 1 || (CLK_HZ / (2 * TONE_HZ)) < 1 ||
        RING_SECONDS < 1 || SNOOZE_SECONDS < 1 || MAX_SNOOZES < 1) begin : g_param_check
        $error("alarm_controller: unsupported parameter set");
    end

    alarm_state_t    r_State;
    alarm_state_t    w_State_Next;
    logic            r_Match_Prev;
    logic            w_Match;
    logic            w_Match_Rise;
    logic [HT_W-1:0] r_Half_Cnt;
    logic            w_Half_Tick;
    logic            w_Tone_Toggle;
    logic            w_Transition;
    logic            w_Ring_Expire;
    logic            w_Snooze_Expire;
    logic            w_Snooze_Ok;
    logic            r_Tone;
    logic            r_Cadence;
    logic            w_Tone_Next;
    logic            w_Cadence_Next;
    logic            r_Alarm_Active;
    logic            r_Snoozing;
    logic            r_Buzzer;

    assign w_Match      = bcd_time_equal(io_Bus.i_Current_Time, io_Bus.i_Alarm_Time) &&
                          (io_Bus.i_Current_PM == io_Bus.i_Alarm_PM);
    // Only a fresh match rings, so arming while already matched stays quiet.
    assign w_Match_Rise = w_Match & ~r_Match_Prev;
    assign w_Transition = (w_State_Next != r_State);

    // Expiry lands on the tick that completes the last half-second.
    assign w_Ring_Expire   = w_Half_Tick && (r_Half_Cnt == HT_W'(RING_HALF - 1));
    assign w_Snooze_Expire = w_Half_Tick && (r_Half_Cnt == HT_W'(SNOOZE_HALF - 1));

    alarm_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TONE_HZ (TONE_HZ)
    ) u_tick_gen (
        .i_Clk         (i_Clk_5MHz),
        .i_Reset       (i_Reset),
        .i_Clear       (w_Transition),
        .i_Tone_Run    (r_State == ST_RINGING),
        .o_Half_Tick   (w_Half_Tick),
        .o_Tone_Toggle (w_Tone_Toggle)
    );

`ifdef ALARM_CTRL_SNOOZE_LIMIT_EN
    localparam int SN_W = $clog2(MAX_SNOOZES + 1) + 1;
    logic [SN_W-1:0] r_Snooze_Cnt;

    assign w_Snooze_Ok = (r_Snooze_Cnt < SN_W'(MAX_SNOOZES));

    // Snoozes taken for the current alarm; forgotten once the alarm is dismissed.
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_Snooze_Cnt <= '0;
        end else if (w_State_Next == ST_ARMED || w_State_Next == ST_DISARMED) begin
            r_Snooze_Cnt <= '0;
        end else if (r_State == ST_RINGING && w_State_Next == ST_SNOOZE) begin
            r_Snooze_Cnt <= r_Snooze_Cnt + SN_W'(1);
        end else begin
            r_Snooze_Cnt <= r_Snooze_Cnt;
        end
    end
`else
    assign w_Snooze_Ok = 1'b1;
`endif

    // Match history for rise detection, tracked in every state.
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_Match_Prev <= 1'b0;
        end else begin
            r_Match_Prev <= w_Match;
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= ST_DISARMED;
        end else begin
            r_State <= w_State_Next;
        end
    end

    // FSM next state: disable > stop > snooze > timer expiry.
    always_comb begin
        w_State_Next = r_State;
        if (!io_Bus.i_Alarm_Enable) begin
            w_State_Next = ST_DISARMED;
        end else begin
            case (r_State)
                ST_DISARMED: begin
                    w_State_Next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_Match_Rise) begin
                        w_State_Next = ST_RINGING;
                    end else begin
                        w_State_Next = ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (io_Bus.i_Stop) begin
                        w_State_Next = ST_ARMED;
                    end else if (io_Bus.i_Snooze && w_Snooze_Ok) begin
                        w_State_Next = ST_SNOOZE;
                    end else if (w_Ring_Expire) begin
                        w_State_Next = ST_ARMED;
                    end else begin
                        w_State_Next = ST_RINGING;
                    end
                end
                ST_SNOOZE: begin
                    if (io_Bus.i_Stop) begin
                        w_State_Next = ST_ARMED;
                    end else if (w_Snooze_Expire) begin
                        w_State_Next = ST_RINGING;
                    end else begin
                        w_State_Next = ST_SNOOZE;
                    end
                end
                default: begin
                    w_State_Next = ST_DISARMED;
                end
            endcase
        end
    end

    // Half-second counter, meaningful only while ringing or snoozing.
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_Half_Cnt <= '0;
        end else if (w_Transition) begin
            r_Half_Cnt <= '0;
        end else if (r_State != ST_RINGING && r_State != ST_SNOOZE) begin
            r_Half_Cnt <= '0;
        end else if (w_Half_Tick) begin
            r_Half_Cnt <= r_Half_Cnt + HT_W'(1);
        end else begin
            r_Half_Cnt <= r_Half_Cnt;
        end
    end

    // Tone and cadence next values: tone starts low, cadence starts high on ring entry.
    always_comb begin
        w_Tone_Next    = 1'b0;
        w_Cadence_Next = 1'b0;
        if (w_State_Next == ST_RINGING) begin
            if (r_State != ST_RINGING) begin
                w_Tone_Next    = 1'b0;
                w_Cadence_Next = 1'b1;
            end else begin
                w_Tone_Next    = r_Tone ^ w_Tone_Toggle;
                w_Cadence_Next = r_Cadence ^ w_Half_Tick;
            end
        end else begin
            w_Tone_Next    = 1'b0;
            w_Cadence_Next = 1'b0;
        end
    end

    // Registered outputs, decoded from the next state so they track the state register.
    always_ff @(posedge i_Clk_5MHz or posedge i_Reset) begin
        if (i_Reset) begin
            r_Tone         <= 1'b0;
            r_Cadence      <= 1'b0;
            r_Alarm_Active <= 1'b0;
            r_Snoozing     <= 1'b0;
            r_Buzzer       <= 1'b0;
        end else begin
            r_Tone         <= w_Tone_Next;
            r_Cadence      <= w_Cadence_Next;
            r_Alarm_Active <= (w_State_Next == ST_RINGING);
            r_Snoozing     <= (w_State_Next == ST_SNOOZE);
            r_Buzzer       <= w_Tone_Next & w_Cadence_Next;
        end
    end

    assign io_Bus.o_Alarm_Active = r_Alarm_Active;
    assign io_Bus.o_Snoozing     = r_Snoozing;
    assign io_Bus.o_Buzzer       = r_Buzzer;

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
// Scoreboard bench: the stimulus process drives inputs on the falling edge,
// steps a behavioural model of the alarm (mode + age since entry, buzzer
// derived arithmetically from the age) and queues the expected outputs for
// the following rising edge. The monitor pops and compares after every
// rising edge, and checks outputs right after an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_alarm_controller;

    localparam int CLK_HZ   = 20;
    localparam int TONE_HZ  = 5;
    localparam int RING_S   = 3;
    localparam int SNOOZE_S = 2;
    localparam int MAX_SN   = 2;

    localparam int RING_CYC   = RING_S * CLK_HZ;
    localparam int SNOOZE_CYC = SNOOZE_S * CLK_HZ;
    localparam int HALF_CYC   = CLK_HZ / 2;
    localparam int TONE_HALF  = CLK_HZ / (2 * TONE_HZ);

    localparam int M_DIS  = 0;
    localparam int M_ARM  = 1;
    localparam int M_RING = 2;
    localparam int M_SNZ  = 3;

    logic clk = 1'b0;
    logic rst;

    alarm_controller_if bus ();

    alarm_controller #(
        .CLK_HZ         (CLK_HZ),
        .TONE_HZ        (TONE_HZ),
        .RING_SECONDS   (RING_S),
        .SNOOZE_SECONDS (SNOOZE_S),
        .MAX_SNOOZES    (MAX_SN)
    ) dut (
        .i_Clk_5MHz (clk),
        .i_Reset    (rst),
        .io_Bus     (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    int         m_mode;
    int         m_age;
    int         m_snz;
    logic       m_prev;
    logic [15:0] alarm_t;
    logic        alarm_pm;

    // Monitor: one comparison per rising edge, plus an immediate check after async reset.
    always @(posedge clk or posedge rst) begin
        logic [2:0] got;
        logic [2:0] e;
        if (clk) begin
            #1;
            got = {bus.o_Alarm_Active, bus.o_Snoozing, bus.o_Buzzer};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty @%0t: got act/snz/buz=%b, required a queued expectation", $time, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got act/snz/buz=%b, required %b", $time, got, e);
                end
            end
        end else begin
            #1;
            got = {bus.o_Alarm_Active, bus.o_Snoozing, bus.o_Buzzer};
            n_vec++;
            if (got !== 3'b000) begin
                n_fail++;
                $display("FAIL async_reset @%0t: got act/snz/buz=%b, required 000", $time, got);
            end
        end
    end

    task automatic model_reset();
        m_mode = M_DIS;
        m_age  = 0;
        m_snz  = 0;
        m_prev = 1'b0;
    endtask

    // One clock edge of alarm behaviour; returns outputs visible after the edge.
    task automatic model_step(input logic en, input logic [15:0] cur, input logic cpm,
                              input logic snz, input logic stp, output logic [2:0] e);
        logic match;
        logic rise;
        logic snz_ok;
        int   nxt;
        match  = (cur == alarm_t) && (cpm == alarm_pm);
        rise   = match && !m_prev;
        m_prev = match;
`ifdef ALARM_CTRL_SNOOZE_LIMIT_EN
        snz_ok = (m_snz < MAX_SN);
`else
        snz_ok = 1'b1;
`endif
        nxt = m_mode;
        if (!en) nxt = M_DIS;
        else if (m_mode == M_DIS) nxt = M_ARM;
        else if (m_mode == M_ARM) nxt = rise ? M_RING : M_ARM;
        else if (m_mode == M_RING) begin
            if (stp) nxt = M_ARM;
            else if (snz && snz_ok) nxt = M_SNZ;
            else if (m_age + 1 == RING_CYC) nxt = M_ARM;
        end else begin
            if (stp) nxt = M_ARM;
            else if (m_age + 1 == SNOOZE_CYC) nxt = M_RING;
        end
        if (m_mode == M_RING && nxt == M_SNZ) m_snz++;
        if (nxt == M_ARM || nxt == M_DIS) m_snz = 0;
        m_age  = (nxt != m_mode) ? 0 : m_age + 1;
        m_mode = nxt;
        e[2] = (m_mode == M_RING);
        e[1] = (m_mode == M_SNZ);
        e[0] = (m_mode == M_RING) && (((m_age / HALF_CYC) % 2) == 0) &&
               (((m_age / TONE_HALF) % 2) == 1);
    endtask

    // Drive one cycle of inputs (from a falling edge), queue the expectation.
    task automatic apply(input logic en, input logic [15:0] cur, input logic cpm,
                         input logic snz, input logic stp);
        logic [2:0] e;
        bus.i_Alarm_Enable = en;
        bus.i_Current_Time = cur;
        bus.i_Current_PM   = cpm;
        bus.i_Alarm_Time   = alarm_t;
        bus.i_Alarm_PM     = alarm_pm;
        bus.i_Snooze       = snz;
        bus.i_Stop         = stp;
        model_step(en, cur, cpm, snz, stp, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic [15:0] cur, input logic cpm);
        for (int i = 0; i < n; i++) apply(1'b1, cur, cpm, 1'b0, 1'b0);
    endtask

    // Start a ring by stepping the time off the alarm and back onto it.
    task automatic ring_up();
        hold(2, 16'h0629, 1'b0);
        apply(1'b1, 16'h0630, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges, held over one rising edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        exp_q.push_back(3'b000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alarm_t  = 16'h0630;
        alarm_pm = 1'b0;
        bus.i_Alarm_Enable = 1'b0;
        bus.i_Current_Time = 16'h0000;
        bus.i_Current_PM   = 1'b0;
        bus.i_Alarm_Time   = alarm_t;
        bus.i_Alarm_PM     = alarm_pm;
        bus.i_Snooze       = 1'b0;
        bus.i_Stop         = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(3'b000);
            @(negedge clk);
        end
        rst = 1'b0;

        // 1/2: ring on a new match, buzzer cadence, timeout, no re-ring while held
        hold(3, 16'h0629, 1'b0);
        apply(1'b1, 16'h0630, 1'b0, 1'b0, 1'b0);
        hold(75, 16'h0630, 1'b0);

        // 3: snooze, re-ring after the snooze time, then stop
        ring_up();
        hold(15, 16'h0630, 1'b0);
        apply(1'b1, 16'h0630, 1'b0, 1'b1, 1'b0);
        hold(45, 16'h0630, 1'b0);
        apply(1'b1, 16'h0630, 1'b0, 1'b0, 1'b1);
        hold(5, 16'h0630, 1'b0);

        // 4: snooze and stop together
        ring_up();
        hold(7, 16'h0630, 1'b0);
        apply(1'b1, 16'h0630, 1'b0, 1'b1, 1'b1);
        hold(10, 16'h0630, 1'b0);

        // 5: disable mid-ring, re-enable while matched
        ring_up();
        hold(12, 16'h0630, 1'b0);
        apply(1'b0, 16'h0630, 1'b0, 1'b0, 1'b0);
        hold(15, 16'h0630, 1'b0);
        ring_up();
        hold(4, 16'h0630, 1'b0);

        // 6a: async reset mid-snooze
        apply(1'b1, 16'h0630, 1'b0, 1'b1, 1'b0);
        hold(8, 16'h0630, 1'b0);
        do_reset();
        hold(5, 16'h0630, 1'b0);

        // 6b: repeated snoozes (third one hits the limit when enabled)
        ring_up();
        for (int k = 0; k < 3; k++) begin
            hold(5, 16'h0630, 1'b0);
            apply(1'b1, 16'h0630, 1'b0, 1'b1, 1'b0);
            hold(SNOOZE_CYC - 1, 16'h0630, 1'b0);
        end
        hold(70, 16'h0630, 1'b0);

        // 7: PM mismatch never rings
        for (int k = 0; k < 4; k++) begin
            hold(3, 16'h0629, 1'b1);
            hold(6, 16'h0630, 1'b1);
        end

        // Randomized traffic around the alarm time
        begin
            logic [15:0] cur;
            logic        cpm;
            cur = 16'h0629;
            cpm = 1'b0;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0: cur = 16'h0630;
                        1: cur = 16'h0629;
                        2: cur = 16'h0631;
                        default: cur = 16'h1159;
                    endcase
                    cpm = ($urandom_range(0, 9) == 0);
                end
                apply($urandom_range(0, 149) != 0, cur, cpm,
                      $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
